// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, tracks fetches through a fixed-latency
// memory and buffers returned {instr, pc} pairs in a small FIFO in front of decode.
module fetch_queue #(
  parameter int                 DATA_W      = 32'd16,
  parameter int                 ADDR_W      = 32'd16,
  parameter int                 DEPTH       = 32'd4,
  parameter int                 MEM_LAT     = 32'd1,
  parameter int                 INSTR_BYTES = 32'd2,
  parameter logic [ADDR_W-1:0]  RESET_PC    = {ADDR_W{1'b0}}
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             fetch_req,
  output logic [ADDR_W-1:0]                fetch_addr,
  input  logic [DATA_W-1:0]                mem_rdata,
  input  logic                             halt,
  input  logic                             flush,
  input  logic [ADDR_W-1:0]                flush_pc,
  output logic                             out_valid,
  output logic [DATA_W-1:0]                out_instr,
  output logic [ADDR_W-1:0]                out_pc,
  input  logic                             out_ready,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic [$clog2(MEM_LAT+1)-1:0]     inflight
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MEM_LAT + 1);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc_r;
  logic              dl_valid_r [MEM_LAT];
  logic [ADDR_W-1:0] dl_pc_r    [MEM_LAT];
  logic [DATA_W-1:0] instr_mem_r [DEPTH];
  logic [ADDR_W-1:0] pc_mem_r    [DEPTH];
  logic [PW-1:0]     rd_ptr_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [CW-1:0]     count_r;
  logic [IW-1:0]     inflight_r;
  logic              out_valid_r;

  logic              issue_s;
  logic              push_s;
  logic              pop_s;
  logic [31:0]       used_s;
  logic [CW-1:0]     count_nxt_s;
  logic [IW-1:0]     inflight_nxt_s;

  // Credit: buffered plus in-flight entries must leave room for every outstanding return
  always_comb begin
    used_s  = 32'(count_r) + 32'(inflight_r);
    issue_s = rst_n & ~flush & ~halt & (used_s < 32'(DEPTH));
    push_s  = dl_valid_r[MEM_LAT-1];
    pop_s   = out_valid_r & out_ready;
  end

  // Next occupancy and in-flight counts; a flush empties both
  always_comb begin
    count_nxt_s    = count_r;
    inflight_nxt_s = inflight_r;
    if (flush) begin
      count_nxt_s    = {CW{1'b0}};
      inflight_nxt_s = {IW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CW'(1'b1);
        2'b01:   count_nxt_s = count_r - CW'(1'b1);
        default: count_nxt_s = count_r;
      endcase
      case ({issue_s, push_s})
        2'b10:   inflight_nxt_s = inflight_r + IW'(1'b1);
        2'b01:   inflight_nxt_s = inflight_r - IW'(1'b1);
        default: inflight_nxt_s = inflight_r;
      endcase
    end
  end

  // Control state: PC, pointers, counters and delay-line valids
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r        <= RESET_PC;
      rd_ptr_r    <= {PW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      inflight_r  <= {IW{1'b0}};
      out_valid_r <= 1'b0;
      for (int i = 0; i < MEM_LAT; i++) dl_valid_r[i] <= 1'b0;
    end else if (flush) begin
      pc_r        <= flush_pc;
      rd_ptr_r    <= {PW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      inflight_r  <= {IW{1'b0}};
      out_valid_r <= 1'b0;
      for (int i = 0; i < MEM_LAT; i++) dl_valid_r[i] <= 1'b0;
    end else begin
      if (issue_s) pc_r <= pc_r + ADDR_W'(INSTR_BYTES);
      if (push_s)  wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      if (pop_s)   rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      count_r     <= count_nxt_s;
      inflight_r  <= inflight_nxt_s;
      out_valid_r <= (count_nxt_s != {CW{1'b0}});
      dl_valid_r[0] <= issue_s;
      for (int i = 1; i < MEM_LAT; i++) dl_valid_r[i] <= dl_valid_r[i-1];
    end
  end

  // Datapath: PC tags ride alongside the memory access; storage needs no reset
  always_ff @(posedge clk) begin
    dl_pc_r[0] <= pc_r;
    for (int i = 1; i < MEM_LAT; i++) dl_pc_r[i] <= dl_pc_r[i-1];
    if (push_s) begin
      instr_mem_r[wr_ptr_r] <= mem_rdata;
      pc_mem_r[wr_ptr_r]    <= dl_pc_r[MEM_LAT-1];
    end
  end

  assign fetch_req  = issue_s;
  assign fetch_addr = pc_r;
  assign out_valid  = out_valid_r;
  assign out_instr  = instr_mem_r[rd_ptr_r];
  assign out_pc     = pc_mem_r[rd_ptr_r];
  assign count      = count_r;
  assign inflight   = inflight_r;

endmodule

// Invariant checker for fetch_queue: credit never oversubscribes the FIFO and
// out_valid tracks occupancy.
module fetch_queue_chk #(
  parameter int DEPTH   = 32'd4,
  parameter int MEM_LAT = 32'd1
) (
  input logic                         clk,
  input logic                         rst_n,
  input logic                         out_valid,
  input logic [$clog2(DEPTH+1)-1:0]   count,
  input logic [$clog2(MEM_LAT+1)-1:0] inflight
);

  // Sampled only once reset has released
  always @(posedge clk) begin
    if (rst_n) begin
      assert (32'(count) + 32'(inflight) <= 32'(DEPTH));
      assert (out_valid == (count != '0));
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue: two instances (MEM_LAT 1 and 3) against a queue-based model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [15:0] KEY = 16'h5A3C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, halt, flush, out_ready;
  logic [15:0] flush_pc;

  logic        fr0, fr1, ov0, ov1;
  logic [15:0] fa0, fa1, oi0, oi1, op0, op1, rd0, rd1;
  logic [2:0]  cnt0, cnt1;
  logic [0:0]  inf0;
  logic [1:0]  inf1;

  // memory models: data = address ^ KEY, valid MEM_LAT cycles after the request
  logic [15:0] m0 [1];
  logic [15:0] m1 [3];
  always @(posedge clk) begin
    m0[0] <= fa0;
    m1[0] <= fa1;
    m1[1] <= m1[0];
    m1[2] <= m1[1];
  end
  assign rd0 = m0[0] ^ KEY;
  assign rd1 = m1[2] ^ KEY;

  fetch_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .MEM_LAT(1), .INSTR_BYTES(2),
                .RESET_PC(16'h0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fr0), .fetch_addr(fa0), .mem_rdata(rd0),
    .halt(halt), .flush(flush), .flush_pc(flush_pc), .out_valid(ov0), .out_instr(oi0),
    .out_pc(op0), .out_ready(out_ready), .count(cnt0), .inflight(inf0));

  fetch_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .MEM_LAT(3), .INSTR_BYTES(2),
                .RESET_PC(16'h0100)) dut1 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fr1), .fetch_addr(fa1), .mem_rdata(rd1),
    .halt(halt), .flush(flush), .flush_pc(flush_pc), .out_valid(ov1), .out_instr(oi1),
    .out_pc(op1), .out_ready(out_ready), .count(cnt1), .inflight(inf1));

  fetch_queue_chk #(.DEPTH(DEPTH), .MEM_LAT(1)) chk0 (
    .clk(clk), .rst_n(rst_n), .out_valid(ov0), .count(cnt0), .inflight(inf0));
  fetch_queue_chk #(.DEPTH(DEPTH), .MEM_LAT(3)) chk1 (
    .clk(clk), .rst_n(rst_n), .out_valid(ov1), .count(cnt1), .inflight(inf1));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit model_ok = 1'b0;

  // reference model: FIFO of PCs, outstanding fetches as (pc, issue cycle)
  int          lat [2] = '{1, 3};
  logic [15:0] rpc [2] = '{16'h0000, 16'h0100};
  logic [15:0] mpc [2];
  logic [15:0] fq    [2][$];
  logic [15:0] iq_pc [2][$];
  int          iq_t  [2][$];

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_k(input int k, input logic fr, input logic [15:0] fa, input logic ov,
                         input logic [15:0] oi, input logic [15:0] op,
                         input logic [2:0] cnt, input logic [1:0] inf);
    int used;
    logic efr;
    used = fq[k].size() + iq_t[k].size();
    efr  = rst_n && !flush && !halt && (used < DEPTH);
    chk("fetch_req", k, 32'(fr), 32'(efr));
    chk("fetch_addr", k, 32'(fa), 32'(mpc[k]));
    chk("out_valid", k, 32'(ov), 32'(fq[k].size() != 0));
    chk("count", k, 32'(cnt), 32'(fq[k].size()));
    chk("inflight", k, 32'(inf), 32'(iq_t[k].size()));
    if (fq[k].size() != 0) begin
      chk("out_pc", k, 32'(op), 32'(fq[k][0]));
      chk("out_instr", k, 32'(oi), 32'(fq[k][0] ^ KEY));
    end
  endtask

  task automatic model_step(input int k);
    bit iss;
    if (!rst_n || flush) begin
      fq[k].delete();
      iq_pc[k].delete();
      iq_t[k].delete();
      mpc[k] = !rst_n ? rpc[k] : flush_pc;
    end else begin
      iss = !halt && (fq[k].size() + iq_t[k].size() < DEPTH);
      if (fq[k].size() != 0 && out_ready) void'(fq[k].pop_front());
      if (iq_t[k].size() != 0 && iq_t[k][0] + lat[k] == cyc) begin
        fq[k].push_back(iq_pc[k].pop_front());
        void'(iq_t[k].pop_front());
      end
      if (iss) begin
        iq_pc[k].push_back(mpc[k]);
        iq_t[k].push_back(cyc);
        mpc[k] = mpc[k] + 16'd2;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (model_ok) begin
      check_k(0, fr0, fa0, ov0, oi0, op0, cnt0, {1'b0, inf0});
      check_k(1, fr1, fa1, ov1, oi1, op1, cnt1, inf1);
    end
    model_step(0);
    model_step(1);
    if (!rst_n) model_ok = 1'b1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; halt = 1'b0; flush = 1'b0; flush_pc = 16'h0000; out_ready = 1'b1;
    repeat (2) cycle();

    rst_n = 1'b1;
    repeat (20) cycle();

    out_ready = 1'b0;
    repeat (10) cycle();
    out_ready = 1'b1;
    repeat (10) cycle();

    out_ready = 1'b0;
    repeat (3) cycle();
    flush = 1'b1; flush_pc = 16'h0040;
    cycle();
    flush = 1'b0; out_ready = 1'b1;
    repeat (12) cycle();

    flush = 1'b1; flush_pc = 16'hFFFA;
    cycle();
    flush = 1'b0;
    repeat (10) cycle();

    halt = 1'b1;
    repeat (5) cycle();
    halt = 1'b0;
    repeat (10) cycle();

    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (8) cycle();

    for (int i = 0; i < 1000; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      halt      = ($urandom_range(0, 11) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      flush_pc  = 16'($urandom) & 16'hFFFE;
      rst_n     = ($urandom_range(0, 199) != 0);
      cycle();
    end

    rst_n = 1'b1; halt = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (10) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
